// File: rtl/pipe_if_id_skid_pkg.sv
// ---------------------------------------------------------------------------
// pipe_if_id_skid_pkg
// Shared definitions for the IF/ID skid buffer:
//   XLEN_DEF      default datapath width for inst / pc / p4
//   NOP_INST_DEF  instruction word presented to decode when the buffer is empty
//                 (sll $0,$0,0)
//   occ_e         occupancy codes EMPTY / ONE / TWO, used directly as FSM state
//   nextOcc       occupancy step for a push/pop pair, ignoring flush
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package pipe_if_id_skid_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // A push and a pop together leave the count unchanged. Push is never
  // offered when full and pop never when empty, so the saturating defaults
  // below are unreachable.
  function automatic occ_e nextOcc(input occ_e cur, input logic push, input logic pop);
    nextOcc = cur;
    if (push && !pop) begin
      case (cur)
        EMPTY:   nextOcc = ONE;
        ONE:     nextOcc = TWO;
        default: nextOcc = TWO;
      endcase
    end else if (pop && !push) begin
      case (cur)
        TWO:     nextOcc = ONE;
        ONE:     nextOcc = EMPTY;
        default: nextOcc = EMPTY;
      endcase
    end
  endfunction

endpackage

// File: rtl/pipe_if_slot.sv
// ---------------------------------------------------------------------------
// pipe_if_slot
// One storage entry of the IF/ID skid buffer holding {inst, pc, p4}.
// Ports:
//   clk      pipeline clock
//   clr      asynchronous active-high reset, zeroes the entry
//   i_we     load i_inst / i_pc / i_p4 on the next rising edge
//   i_inst   instruction to store
//   i_pc     pc of that instruction
//   i_p4     pc+4 of that instruction
//   o_inst   stored instruction
//   o_pc     stored pc
//   o_p4     stored pc+4
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_if_slot
  import pipe_if_id_skid_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_p4,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_p4
);

  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_p4;

  // Contents are only zeroed on reset; a pop or a flush leaves stale data
  // here because the top-level occupancy decides whether it is visible.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_inst <= '0;
      r_pc   <= '0;
      r_p4   <= '0;
    end else if (i_we) begin
      r_inst <= i_inst;
      r_pc   <= i_pc;
      r_p4   <= i_p4;
    end
  end

  assign o_inst = r_inst;
  assign o_pc   = r_pc;
  assign o_p4   = r_p4;

endmodule

// File: rtl/pipe_if_id_skid.sv
// ---------------------------------------------------------------------------
// pipe_if_id_skid
// IF/ID boundary buffer: a 2-entry skid FIFO between fetch and decode. It
// absorbs decode stalls without losing a fetched word, throttles fetch through
// IFwip, and discards wrong-path words on flush.
// Ports:
//   clk        pipeline clock
//   clr        asynchronous active-high reset (dominates flush and push)
//   if_valid   fetch presents a word this cycle
//   if_inst    fetched instruction
//   if_pc      pc of fetched instruction
//   if_p4      pc+4 of fetched instruction
//   IFwip      PC write enable back to fetch (1 = fetch may advance)
//   flush      taken jump/branch resolved downstream, drop everything held
//   id_ready   decode accepts the head entry this cycle
//   id_valid   head entry valid
//   id_inst    head instruction, NOP_INST when empty
//   id_pc      head pc, 0 when empty
//   id_p4      head pc+4, 0 when empty
//   occupancy  entries held (0..2)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_if_id_skid
  import pipe_if_id_skid_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEF)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_p4,
  output logic            IFwip,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_p4,
  output logic [1:0]      occupancy
);

  occ_e            r_state;
  occ_e            w_nextState;
  logic            r_wrPtr;
  logic            r_rdPtr;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_inst0;
  logic [XLEN-1:0] w_pc0;
  logic [XLEN-1:0] w_p40;
  logic [XLEN-1:0] w_inst1;
  logic [XLEN-1:0] w_pc1;
  logic [XLEN-1:0] w_p41;

  // IFwip depends only on state and flush so there is no combinational path
  // from if_valid or id_ready back into fetch. When full, the pop of this
  // cycle frees a slot, but the refill waits for the next cycle.
  assign w_full   = (r_state == TWO);
  assign IFwip    = !w_full || flush;
  assign id_valid = (r_state != EMPTY);
  assign w_push   = if_valid && IFwip && !flush;
  assign w_pop    = id_valid && id_ready && !flush;

  pipe_if_slot #(.XLEN(XLEN)) u_slot0 (
    .clk    (clk),
    .clr    (clr),
    .i_we   (w_push && !r_wrPtr),
    .i_inst (if_inst),
    .i_pc   (if_pc),
    .i_p4   (if_p4),
    .o_inst (w_inst0),
    .o_pc   (w_pc0),
    .o_p4   (w_p40)
  );

  pipe_if_slot #(.XLEN(XLEN)) u_slot1 (
    .clk    (clk),
    .clr    (clr),
    .i_we   (w_push && r_wrPtr),
    .i_inst (if_inst),
    .i_pc   (if_pc),
    .i_p4   (if_p4),
    .o_inst (w_inst1),
    .o_pc   (w_pc1),
    .o_p4   (w_p41)
  );

  // Occupancy state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Flush empties the buffer regardless of any push or pop this cycle.
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = EMPTY;
    end else begin
      w_nextState = nextOcc(r_state, w_push, w_pop);
    end
  end

  // One-bit pointers wrap naturally; flush realigns both to slot 0.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else if (flush) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= !r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= !r_rdPtr;
      end
    end
  end

  // Head mux: decode sees the slot under the read pointer only when something
  // is held, otherwise a NOP with zero pc fields.
  always_comb begin
    id_inst = NOP_INST;
    id_pc   = '0;
    id_p4   = '0;
    if (id_valid) begin
      if (r_rdPtr) begin
        id_inst = w_inst1;
        id_pc   = w_pc1;
        id_p4   = w_p41;
      end else begin
        id_inst = w_inst0;
        id_pc   = w_pc0;
        id_p4   = w_p40;
      end
    end
  end

  assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_if_id_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_if_id_skid
// Directed bench for the IF/ID skid buffer with a queue scoreboard holding the
// words the buffer should currently contain, head first.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipe_if_id_skid;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] p4;
  } ent_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        clr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_p4;
  logic        IFwip;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_p4;
  logic [1:0]  occupancy;

  ent_t sb[$];
  int   nTests = 0;
  int   nFail  = 0;

  pipe_if_id_skid dut (
    .clk       (clk),
    .clr       (clr),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .if_p4     (if_p4),
    .IFwip     (IFwip),
    .flush     (flush),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_inst   (id_inst),
    .id_pc     (id_pc),
    .id_p4     (id_p4),
    .occupancy (occupancy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp)
      else begin
        nFail++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Compare every output against the scoreboard contents and current flush.
  task automatic checkOutput(input string tag);
    ent_t        head;
    logic        expValid;
    logic        expWip;
    logic [31:0] expInst;
    expValid = (sb.size() != 0);
    head     = '0;
    expInst  = NOP;
    if (expValid) begin
      head    = sb[0];
      expInst = head.inst;
    end
    expWip = (sb.size() != 2) || flush;
    checkEq({tag, ".valid"}, {31'b0, id_valid}, {31'b0, expValid});
    checkEq({tag, ".inst"},  id_inst, expInst);
    checkEq({tag, ".pc"},    id_pc, head.pc);
    checkEq({tag, ".p4"},    id_p4, head.p4);
    checkEq({tag, ".ifwip"}, {31'b0, IFwip}, {31'b0, expWip});
    checkEq({tag, ".occ"},   {30'b0, occupancy}, 32'(sb.size()));
  endtask

  // One clock cycle: drive inputs, check on the falling edge, then advance the
  // scoreboard by what the coming rising edge should do.
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                               input logic rdy, input logic fl, input string tag);
    logic doPush;
    logic doPop;
    ent_t e;
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    if_p4    = pc + 32'd4;
    id_ready = rdy;
    flush    = fl;
    @(negedge clk);
    checkOutput(tag);
    doPush = v && (sb.size() != 2) && !fl;
    doPop  = (sb.size() != 0) && rdy && !fl;
    e.inst = inst;
    e.pc   = pc;
    e.p4   = pc + 32'd4;
    if (fl) begin
      sb.delete();
    end else begin
      if (doPop) void'(sb.pop_front());
      if (doPush) sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Raise clr away from a clock edge with the given push/flush activity,
  // hold it across an edge, then release.
  task automatic applyClear(input logic v, input logic fl, input string tag);
    if_valid = v;
    if_inst  = 32'hDEAD_BEEF;
    if_pc    = 32'h0000_0F00;
    if_p4    = 32'h0000_0F04;
    flush    = fl;
    #2;
    clr = 1'b1;
    #1;
    sb.delete();
    checkOutput({tag, ".now"});
    @(posedge clk);
    #1;
    checkOutput({tag, ".edge"});
    clr      = 1'b0;
    if_valid = 1'b0;
    flush    = 1'b0;
    #1;
    checkOutput({tag, ".drop"});
  endtask

  initial begin
    int          pushed;
    int          cyc;
    logic        willPush;
    logic [6:0]  pat;

    clr      = 1'b1;
    if_valid = 1'b0;
    if_inst  = '0;
    if_pc    = '0;
    if_p4    = '0;
    flush    = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    clr = 1'b0;
    #1;

    // Reset mid-stream with the buffer full.
    applyStimulus(1'b1, 32'h1111_0001, 32'h0000_0000, 1'b0, 1'b0, "t1.fillA");
    applyStimulus(1'b1, 32'h1111_0002, 32'h0000_0004, 1'b0, 1'b0, "t1.fillB");
    applyStimulus(1'b1, 32'h1111_0003, 32'h0000_0008, 1'b0, 1'b0, "t1.full");
    applyClear(1'b1, 1'b0, "t1.clr");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t1.idle");

    // Streaming: each word one cycle later, occupancy held at 1.
    applyStimulus(1'b1, 32'h8C01_0004, 32'h0000_0000, 1'b1, 1'b0, "t2.s0");
    applyStimulus(1'b1, 32'h0022_1820, 32'h0000_0004, 1'b1, 1'b0, "t2.s1");
    applyStimulus(1'b1, 32'hAC03_0008, 32'h0000_0008, 1'b1, 1'b0, "t2.s2");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t2.s3");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t2.s4");

    // Decode stall: C refused while full, fetch holds it until accepted.
    applyStimulus(1'b1, 32'hA000_000A, 32'h0000_0010, 1'b0, 1'b0, "t3.A");
    applyStimulus(1'b1, 32'hB000_000B, 32'h0000_0014, 1'b0, 1'b0, "t3.B");
    applyStimulus(1'b1, 32'hC000_000C, 32'h0000_0018, 1'b0, 1'b0, "t3.Cfull");
    applyStimulus(1'b1, 32'hC000_000C, 32'h0000_0018, 1'b1, 1'b0, "t3.popA");
    applyStimulus(1'b1, 32'hC000_000C, 32'h0000_0018, 1'b1, 1'b0, "t3.popB");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t3.popC");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t3.empty");

    // Flush while full with a word arriving.
    applyStimulus(1'b1, 32'h3000_0001, 32'h0000_0020, 1'b0, 1'b0, "t4.fill1");
    applyStimulus(1'b1, 32'h3000_0002, 32'h0000_0024, 1'b0, 1'b0, "t4.fill2");
    applyStimulus(1'b1, 32'h3000_0003, 32'h0000_0028, 1'b0, 1'b1, "t4.flush");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "t4.after");
    applyStimulus(1'b1, 32'h2001_0005, 32'h0000_0040, 1'b0, 1'b0, "t4.push");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t4.alone");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t4.empty");

    // Pointer wrap with an irregular pop pattern 1,0,1,1,0,1,1.
    pat    = 7'b1101101;
    pushed = 0;
    cyc    = 0;
    while (pushed < 7 && cyc < 40) begin
      willPush = (sb.size() != 2);
      applyStimulus(1'b1, 32'h5000_0000 + 32'(pushed), 32'h0000_0100 + 32'(pushed * 4),
                    pat[cyc % 7], 1'b0, "t5.wrap");
      if (willPush) pushed++;
      cyc++;
    end
    checkEq("t5.pushes", 32'(pushed), 32'd7);
    repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t5.drain");

    // clr, flush and push together.
    applyStimulus(1'b1, 32'h6000_0001, 32'h0000_0200, 1'b0, 1'b0, "t6.pre");
    applyClear(1'b1, 1'b1, "t6.clr");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "t6.idle");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
